// File: rtl/wrap_up_counter.sv
// wrap_up_counter: free-running WIDTH-bit up-counter, wraps mod 2^WIDTH.
// Ports: reset (sync, active-high), clk, count (registered), tc (opt).
//
// Optional feature macro: WRAP_UP_COUNTER_TC_EN
//   defined   -> trailing output tc = (count == all ones)
//   undefined -> three-port interface (reset, clk, count) only
//
// Port order is fixed so positional instances (reset, clk, count[, tc])
// bind correctly; #(N) positionally selects WIDTH.

module wrap_up_counter #(
  parameter int WIDTH = 8
) (
  input  logic             reset,
  input  logic             clk,
  output logic [WIDTH-1:0] count
`ifdef WRAP_UP_COUNTER_TC_EN
  ,
  output logic             tc
`endif
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Truncating add gives the wrap from all ones back to zero.
  always_comb begin
    count_d = count_q + WIDTH'(1);
  end

  // Reset has priority over the increment, including at the wrap edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

`ifdef WRAP_UP_COUNTER_TC_EN
  // Decoded from the register, so high exactly the cycle before a wrap.
  assign tc = &count_q;
`endif

endmodule

// File: tb/tb_wrap_up_counter.sv
// tb_wrap_up_counter: directed + random checks of wrap_up_counter.
// Reference is a plain modulo-16 integer model.

module tb_wrap_up_counter;

  localparam int W = 4;
  localparam int MOD = 1 << W;

  logic         reset;
  logic         clk;
  logic [W-1:0] count;
`ifdef WRAP_UP_COUNTER_TC_EN
  logic         tc;
`endif

  int checks = 0;
  int errors = 0;
  int model = 0;

  wrap_up_counter #(.WIDTH(W)) dut (
    .reset (reset),
    .clk   (clk),
    .count (count)
`ifdef WRAP_UP_COUNTER_TC_EN
    ,
    .tc    (tc)
`endif
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int exp);
    checks++;
    assert (count === W'(exp)) else begin
      errors++;
      $error("FAIL %s: got %0d want %0d", tag, count, exp);
    end
`ifdef WRAP_UP_COUNTER_TC_EN
    checks++;
    assert (tc === (exp == MOD - 1)) else begin
      errors++;
      $error("FAIL %s_tc: got %0b want %0b",
             tag, tc, (exp == MOD - 1));
    end
`endif
  endtask

  // One rising edge with the given reset level, then check.
  task automatic step(input logic r, input string tag);
    reset = r;
    @(posedge clk);
    model = r ? 0 : (model + 1) % MOD;
    #1;
    chk(tag, model);
  endtask

  initial begin
    reset = 1'b1;
    @(negedge clk);

    step(1'b1, "rst1");
    for (int i = 0; i < 3; i++) step(1'b1, "rst_hold");

    for (int i = 1; i <= 15; i++) begin
      step(1'b0, "inc");
      checks++;
      assert (count === W'(i)) else begin
        errors++;
        $error("FAIL inc_abs: got %0d want %0d", count, i);
      end
    end

    step(1'b0, "wrap");
    for (int i = 0; i < 3; i++) step(1'b0, "post_wrap");

    step(1'b1, "mid_rst");
    step(1'b0, "mid_rel");

    // Reset raised between edges must not act until the next edge.
    @(negedge clk);
    reset = 1'b1;
    #5;
    chk("async_none", model);
    @(posedge clk);
    model = 0;
    #1;
    chk("async_edge", model);

    // Reset coinciding with the wrap edge.
    reset = 1'b0;
    while (model != MOD - 1) step(1'b0, "to_top");
    step(1'b1, "rst_at_wrap");

    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 9) == 0), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
